// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU modes, register-index constants and ID/EX stage record
package cpu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int CTRL_WIDTH     = 4;
  localparam int REG_ADDR_WIDTH = 5;

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

  typedef enum logic [CTRL_WIDTH-1:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    SLT = 4'd5,
    SLL = 4'd6,
    SRL = 4'd7,
    SRA = 4'd8
  } alumodes;

  typedef struct packed {
    logic                      valid;
    logic                      memread;
    logic                      memwrite;
    logic                      regwrite;
    logic                      op1_pc;
    logic                      op2_imm;
    alumodes                   ctrl;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0]     rs1_data;
    logic [DATA_WIDTH-1:0]     rs2_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
  } id_ex_t;

  localparam id_ex_t BUBBLE = id_ex_t'('0);

endpackage

// File: rtl/ex_operand_stage_fwd_sel.sv
// rtl/ex_operand_stage_fwd_sel.sv - priority forwarding mux for one source operand
module fwd_sel #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_i,
  input  logic [DATA_WIDTH-1:0]     src_data_i,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                      exmem_regwrite_i,
  input  logic [DATA_WIDTH-1:0]     exmem_result_i,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                      memwb_regwrite_i,
  input  logic [DATA_WIDTH-1:0]     memwb_result_i,
  output logic [DATA_WIDTH-1:0]     fwd_o
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == src_i);
  assign memwb_hit = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == src_i);

  // x0 reads zero even if the register-file data input is not zero
  always_comb begin
    fwd_o = src_data_i;
    if (src_i == '0) begin
      fwd_o = '0;
    end else if (exmem_hit) begin
      fwd_o = exmem_result_i;
    end else if (memwb_hit) begin
      fwd_o = memwb_result_i;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with forwarding and load-use stall
// Optional bubble_count output and counter when EX_OPERAND_PERF_EN is defined.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int CONTROLL_WIDTH = cpu_pkg::CTRL_WIDTH,
  parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [DATA_WIDTH-1:0]     id_pc,
  input  logic                      id_op1_pc,
  input  logic                      id_op2_imm,
  input  logic [CONTROLL_WIDTH-1:0] id_ctrl,
  input  logic                      id_memread,
  input  logic                      id_memwrite,
  input  logic                      id_regwrite,
  input  logic                      flush,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic                      exmem_regwrite,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic                      memwb_regwrite,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     op1,
  output logic [DATA_WIDTH-1:0]     op2,
  output logic [CONTROLL_WIDTH-1:0] ctrl,
  output logic                      ex_valid,
  output logic                      ex_memread,
  output logic                      ex_memwrite,
  output logic                      ex_regwrite,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic [DATA_WIDTH-1:0]     ex_pc,
  output logic [DATA_WIDTH-1:0]     ex_store_data,
`ifdef EX_OPERAND_PERF_EN
  output logic [31:0]               bubble_count,
`endif
  output logic                      stall_id
);

  cpu_pkg::id_ex_t         stage_q;
  cpu_pkg::id_ex_t         stage_d;
  logic                    hz;
  logic [DATA_WIDTH-1:0]   fwd_rs1;
  logic [DATA_WIDTH-1:0]   fwd_rs2;

  assign hz = stage_q.valid && stage_q.memread && (stage_q.rd != cpu_pkg::X0) && id_valid &&
              ((stage_q.rd == id_rs1) || (stage_q.rd == id_rs2));

  // Gated by rst so a stall in flight drops the moment reset is sampled
  assign stall_id = hz && !flush && !rst;

  always_comb begin
    stage_d          = cpu_pkg::BUBBLE;
    stage_d.valid    = id_valid;
    stage_d.memread  = id_memread;
    stage_d.memwrite = id_memwrite;
    stage_d.regwrite = id_regwrite;
    stage_d.op1_pc   = id_op1_pc;
    stage_d.op2_imm  = id_op2_imm;
    stage_d.ctrl     = cpu_pkg::alumodes'(id_ctrl);
    stage_d.rd       = id_rd;
    stage_d.rs1      = id_rs1;
    stage_d.rs2      = id_rs2;
    stage_d.rs1_data = id_rs1_data;
    stage_d.rs2_data = id_rs2_data;
    stage_d.imm      = id_imm;
    stage_d.pc       = id_pc;
    if (flush || hz) begin
      stage_d = cpu_pkg::BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= cpu_pkg::BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .src_i            (stage_q.rs1),
    .src_data_i       (stage_q.rs1_data),
    .exmem_rd_i       (exmem_rd),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_result_i   (exmem_result),
    .memwb_rd_i       (memwb_rd),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_result_i   (memwb_result),
    .fwd_o            (fwd_rs1)
  );

  fwd_sel #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .src_i            (stage_q.rs2),
    .src_data_i       (stage_q.rs2_data),
    .exmem_rd_i       (exmem_rd),
    .exmem_regwrite_i (exmem_regwrite),
    .exmem_result_i   (exmem_result),
    .memwb_rd_i       (memwb_rd),
    .memwb_regwrite_i (memwb_regwrite),
    .memwb_result_i   (memwb_result),
    .fwd_o            (fwd_rs2)
  );

  assign op1           = stage_q.op1_pc  ? stage_q.pc  : fwd_rs1;
  assign op2           = stage_q.op2_imm ? stage_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ctrl          = stage_q.ctrl;
  assign ex_valid      = stage_q.valid;
  assign ex_memread    = stage_q.memread;
  assign ex_memwrite   = stage_q.memwrite;
  assign ex_regwrite   = stage_q.regwrite;
  assign ex_rd         = stage_q.rd;
  assign ex_pc         = stage_q.pc;

`ifdef EX_OPERAND_PERF_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((flush || hz) && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - directed self-checking bench for ex_operand_stage
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_op1_pc, id_op2_imm;
  logic [3:0]  id_ctrl;
  logic        id_memread, id_memwrite, id_regwrite;
  logic        flush;
  logic [4:0]  exmem_rd;
  logic        exmem_regwrite;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite;
  logic [31:0] memwb_result;
  logic [31:0] op1, op2;
  logic [3:0]  ctrl;
  logic        ex_valid, ex_memread, ex_memwrite, ex_regwrite;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_store_data;
  logic        stall_id;
`ifdef EX_OPERAND_PERF_EN
  logic [31:0] bubble_count;
  logic [31:0] cnt_before;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .id_op1_pc(id_op1_pc), .id_op2_imm(id_op2_imm),
    .id_ctrl(id_ctrl), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_regwrite(id_regwrite), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .op1(op1), .op2(op2), .ctrl(ctrl),
    .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_store_data(ex_store_data),
`ifdef EX_OPERAND_PERF_EN
    .bubble_count(bubble_count),
`endif
    .stall_id(stall_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
    id_op1_pc = 0; id_op2_imm = 0; id_ctrl = 0;
    id_memread = 0; id_memwrite = 0; id_regwrite = 0; flush = 0;
  endtask

  task automatic fwd_clear();
    exmem_rd = 0; exmem_regwrite = 0; exmem_result = 0;
    memwb_rd = 0; memwb_regwrite = 0; memwb_result = 0;
  endtask

  task automatic id_set(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic o1pc, input logic o2imm,
                        input logic [3:0] c, input logic mr, input logic mw, input logic rw);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    id_op1_pc = o1pc; id_op2_imm = o2imm; id_ctrl = c;
    id_memread = mr; id_memwrite = mw; id_regwrite = rw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    id_clear();
    fwd_clear();
    rst = 1;
    // reset held with a live instruction at ID
    id_set(5'd3, 5'd4, 5'd9, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 4'd1, 1, 0, 1);
    step();
    step();
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_ctrl", {28'b0, ctrl}, 32'd0);
    chk("rst_op1", op1, 32'd0);
    chk("rst_op2", op2, 32'd0);
    chk("rst_stall", {31'b0, stall_id}, 32'd0);
    chk("rst_rd", {27'b0, ex_rd}, 32'd0);

    // addi x5,x0,7 with junk on the x0 data input
    rst = 0;
    id_set(5'd0, 5'd0, 5'd5, 32'h55, 32'h0, 32'd7, 32'h100, 0, 1, 4'd0, 0, 0, 1);
    step();
    chk("addi_op1", op1, 32'd0);
    chk("addi_op2", op2, 32'd7);
    chk("addi_ctrl", {28'b0, ctrl}, 32'd0);
    chk("addi_valid", {31'b0, ex_valid}, 32'd1);
    chk("addi_rd", {27'b0, ex_rd}, 32'd5);
    chk("addi_pc", ex_pc, 32'h100);

    // forwarding priority on rs1=x3
    id_set(5'd3, 5'd2, 5'd8, 32'h99, 32'h44, 32'h0, 32'h104, 0, 0, 4'd1, 0, 0, 1);
    step();
    id_clear();
    chk("fwd_none_op1", op1, 32'h99);
    exmem_rd = 5'd3; exmem_regwrite = 1; exmem_result = 32'h11;
    #1;
    chk("fwd_exmem_op1", op1, 32'h11);
    chk("fwd_exmem_op2", op2, 32'h44);
    chk("fwd_ctrl_sub", {28'b0, ctrl}, 32'd1);
    memwb_rd = 5'd3; memwb_regwrite = 1; memwb_result = 32'h22;
    #1;
    chk("fwd_both_op1", op1, 32'h11);
    exmem_regwrite = 0;
    #1;
    chk("fwd_memwb_op1", op1, 32'h22);
    fwd_clear();

    // x0 never forwarded
    id_set(5'd1, 5'd0, 5'd9, 32'h5, 32'h77, 32'h0, 32'h108, 0, 0, 4'd0, 0, 0, 1);
    step();
    id_clear();
    exmem_rd = 5'd0; exmem_regwrite = 1; exmem_result = 32'hFFFF_FFFF;
    memwb_rd = 5'd0; memwb_regwrite = 1; memwb_result = 32'hFFFF_FFFF;
    #1;
    chk("x0_op2", op2, 32'd0);
    chk("x0_store", ex_store_data, 32'd0);
    chk("x0_op1", op1, 32'h5);
    fwd_clear();

    // load-use: lw x4,4(x1) then add x6,x4,x1
    id_set(5'd1, 5'd0, 5'd4, 32'h200, 32'h0, 32'd4, 32'h10c, 0, 1, 4'd0, 1, 0, 1);
    step();
    chk("lw_memread", {31'b0, ex_memread}, 32'd1);
    id_set(5'd4, 5'd1, 5'd6, 32'h0, 32'h200, 32'h0, 32'h110, 0, 0, 4'd0, 0, 0, 1);
    #1;
    chk("lu_stall", {31'b0, stall_id}, 32'd1);
    step();
    chk("lu_bubble_rw", {31'b0, ex_regwrite}, 32'd0);
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu_stall_once", {31'b0, stall_id}, 32'd0);
    step();
    memwb_rd = 5'd4; memwb_regwrite = 1; memwb_result = 32'h1234;
    #1;
    chk("lu_add_rd", {27'b0, ex_rd}, 32'd6);
    chk("lu_add_op1", op1, 32'h1234);
    chk("lu_add_op2", op2, 32'h200);
    fwd_clear();

    // flush wins over load-use
    id_set(5'd1, 5'd0, 5'd4, 32'h200, 32'h0, 32'd4, 32'h114, 0, 1, 4'd0, 1, 0, 1);
    step();
    id_set(5'd4, 5'd1, 5'd6, 32'h0, 32'h200, 32'h0, 32'h118, 0, 0, 4'd0, 0, 0, 1);
    flush = 1;
    #1;
    chk("fl_stall", {31'b0, stall_id}, 32'd0);
`ifdef EX_OPERAND_PERF_EN
    cnt_before = bubble_count;
`endif
    step();
    flush = 0;
    chk("fl_valid", {31'b0, ex_valid}, 32'd0);
    chk("fl_rw", {31'b0, ex_regwrite}, 32'd0);
`ifdef EX_OPERAND_PERF_EN
    chk("fl_count", bubble_count, cnt_before + 32'd1);
`endif

    // sw x7,8(x2): op2 is imm, store data forwarded
    id_set(5'd2, 5'd7, 5'd0, 32'h100, 32'h5, 32'd8, 32'h11c, 0, 1, 4'd0, 0, 1, 0);
    step();
    id_clear();
    exmem_rd = 5'd7; exmem_regwrite = 1; exmem_result = 32'hAB;
    #1;
    chk("sw_op2", op2, 32'd8);
    chk("sw_store", ex_store_data, 32'hAB);
    chk("sw_memwrite", {31'b0, ex_memwrite}, 32'd1);
    fwd_clear();

    // auipc: op1 from pc
    id_set(5'd0, 5'd0, 5'd10, 32'h0, 32'h0, 32'h3000, 32'h1000, 1, 1, 4'd0, 0, 0, 1);
    step();
    chk("auipc_op1", op1, 32'h1000);
    chk("auipc_op2", op2, 32'h3000);

    // reset while a load-use stall is pending
    id_set(5'd1, 5'd0, 5'd4, 32'h200, 32'h0, 32'd4, 32'h120, 0, 1, 4'd0, 1, 0, 1);
    step();
    id_set(5'd4, 5'd4, 5'd6, 32'h0, 32'h0, 32'h0, 32'h124, 0, 0, 4'd0, 0, 0, 1);
    #1;
    chk("rs_stall_pre", {31'b0, stall_id}, 32'd1);
    rst = 1;
    #1;
    chk("rs_stall_drop", {31'b0, stall_id}, 32'd0);
    step();
    chk("rs_valid", {31'b0, ex_valid}, 32'd0);
`ifdef EX_OPERAND_PERF_EN
    chk("rs_count", bubble_count, 32'd0);
`endif
    rst = 0;
    id_clear();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding and load-use hazard logic. Sits directly upstream of the ALU.
- Captures decoded instruction fields each cycle and resolves RAW hazards from the EX/MEM and MEM/WB stages.
- Drives op1, op2 and ctrl into the ALU; raises a stall to the fetch/decode front-end on load-use.

Parameters:
DATA_WIDTH, 32, operand/result width
CONTROLL_WIDTH, 4, ALU control width
REG_ADDR_WIDTH, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  decode stage holds a real instruction
id_rs1, id_rs2, id_rd  in  REG_ADDR_WIDTH  source/destination indices
id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
id_imm, id_pc  in  DATA_WIDTH  immediate, instruction PC
id_op1_pc  in  1  op1 := pc (auipc/jal)
id_op2_imm  in  1  op2 := imm
id_ctrl  in  CONTROLL_WIDTH  ALU mode
id_memread, id_memwrite, id_regwrite  in  1  control bits
flush  in  1  branch/jump taken; kill decode instruction
exmem_rd  in  REG_ADDR_WIDTH; exmem_regwrite  in  1; exmem_result  in  DATA_WIDTH
memwb_rd  in  REG_ADDR_WIDTH; memwb_regwrite  in  1; memwb_result  in  DATA_WIDTH
op1, op2  out  DATA_WIDTH  ALU operands (combinational from stage register + forwarding)
ctrl  out  CONTROLL_WIDTH  ALU mode
ex_valid, ex_memread, ex_memwrite, ex_regwrite  out  1  registered control
ex_rd  out  REG_ADDR_WIDTH; ex_pc  out  DATA_WIDTH
ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
stall_id  out  1  hold PC and IF/ID register this cycle

Behaviour:
- Reset (sync, rst high at edge): stage register = bubble. ex_valid=0, ex_memread=ex_memwrite=ex_regwrite=0, ex_rd=0, ex_pc=0, ctrl=ADD(0), stored rs data/imm=0. Hence op1=op2=0 and stall_id=0 while held in reset.
- Latency: one cycle. Fields presented at ID at edge N appear at ALU inputs after edge N.
- Load-use hazard (combinational): hz = ex_valid & ex_memread & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- stall_id = hz & ~flush.
- Next-state selection, by priority:
  - rst: bubble.
  - flush: bubble.
  - hz: bubble; the ID instruction is held upstream and re-presented next cycle.
  - otherwise: capture ID fields.
  - ex_valid := id_valid in the capture case.
- Bubble = all control bits 0, ctrl=ADD, rd=0.
- Forwarding, per source s in {rs1, rs2}, using registered indices:
  - If exmem_regwrite & exmem_rd!=0 & exmem_rd==s: take exmem_result.
  - Else if memwb_regwrite & memwb_rd!=0 & memwb_rd==s: take memwb_result.
  - Else: take the registered read data.
  - EX/MEM always beats MEM/WB when both match.
  - x0 is never forwarded; a registered x0 source reads 0 regardless of the data input.
- op1 = op1_pc ? ex_pc : fwd_rs1.
- op2 = op2_imm ? imm : fwd_rs2.
- ex_store_data = fwd_rs2 always, independent of op2_imm.
- Hazard and forwarding paths are combinational. No combinational path from op1/op2 back to stall_id.
- Simultaneous events:
  - flush and hz together: flush wins; bubble inserted and stall_id=0.
  - Back-to-back loads to the same rd stall exactly one cycle each.
- Reset mid-stall: stall_id drops in the same cycle rst is sampled; the pipeline restarts clean.

Optional Feature:
- Macro: EX_OPERAND_PERF_EN.
- Defined: adds output port bubble_count (32 bits) and an internal 32-bit counter.
  - Counter increments once per cycle in which a bubble is inserted due to hz or flush.
  - Saturates at all-ones; cleared by rst.
- Undefined: no port and no counter. All other behaviour is identical.

Decomposition:
- Shared package (cpu_pkg):
  - alumodes enum (ADD=0, SUB=1, AND=2, OR=3, SLT=5, SLL=6, SRL=7, SRA=8).
  - REG_ADDR_WIDTH and the X0 constant.
  - Packed struct id_ex_t holding all registered fields.
  - BUBBLE constant of type id_ex_t.
- Sub-module fwd_sel: one instance per source operand. Implements the priority forwarding compare and mux.

Test Plan:
1. rst high 2 cycles with id_valid=1 inputs -> ex_valid=0, ctrl=0, op1=op2=0, stall_id=0. Release -> addi x5,x0,7 (imm=7, op2_imm=1) gives op1=0, op2=7, ctrl=ADD next cycle.
2. EX/MEM forward: registered rs1=x3, exmem_rd=3, exmem_regwrite=1, exmem_result=0x11, rf data 0x99 -> op1=0x11. Add memwb_rd=3, result 0x22 -> op1 still 0x11. Remove the exmem match -> op1=0x22.
3. x0 guard: rs2=x0, exmem_rd=0, exmem_regwrite=1, result 0xFFFF_FFFF -> op2=0.
4. Load-use: lw x4 in EX (memread=1), ID add x6,x4,x1 -> stall_id=1 for exactly 1 cycle and EX holds a bubble (ex_regwrite=0). Next cycle the add captures with memwb forwarding of x4.
5. Flush with hz: same setup plus flush=1 -> stall_id=0, bubble captured; with EX_OPERAND_PERF_EN, bubble_count increments by 1.
6. Store data: sw with rs2=x7, op2_imm=1, imm=8, exmem_rd=7 result 0xAB -> op2=8, ex_store_data=0xAB.
